// File: rtl/systolic_pkg.sv
// systolic_pkg: shared FSM state type and FEED-length/counter-width helpers for the systolic sequencer
package systolic_pkg;
  typedef enum logic [2:0] {IDLE, W_COLLECT, W_SHIFT, D_COLLECT, FEED, DRAIN, DONE} state_t;
  localparam int PERF_W = 32;
  function automatic int feed_len(input int depth);
    return 2 * depth - 1;
  endfunction
  function automatic int cnt_w(input int depth, input int drain);
    return $clog2((feed_len(depth) > drain ? feed_len(depth) : drain) + 1);
  endfunction
endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: weight-word and data-vector valid/ready handshakes of the systolic sequencer
interface systolic_seq_ctrl_if #(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 8
);
  logic                       w_valid;
  logic                       w_ready;
  logic [BIT_WIDTH*DEPTH-1:0] w_data;
  logic                       d_valid;
  logic                       d_ready;
  logic [BIT_WIDTH*DEPTH-1:0] d_data;
  modport master (output w_valid, w_data, d_valid, d_data, input w_ready, d_ready);
  modport slave  (input w_valid, w_data, d_valid, d_data, output w_ready, d_ready);
endinterface

// File: rtl/systolic_skew_buf.sv
// systolic_skew_buf: diagonal skew, lane i of the vector is delayed by i registers
module systolic_skew_buf #(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BIT_WIDTH*DEPTH-1:0] in_vec,
  output logic [BIT_WIDTH*DEPTH-1:0] out_vec
);
  genvar i;
  for (i = 0; i < DEPTH; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign out_vec[0 +: BIT_WIDTH] = in_vec[0 +: BIT_WIDTH];
    end else begin : g_dly
      logic [BIT_WIDTH-1:0] sr_q [i];
      logic [BIT_WIDTH-1:0] sr_d [i];
      always_comb begin
        sr_d[0] = in_vec[i*BIT_WIDTH +: BIT_WIDTH];
        for (int k = 1; k < i; k++) sr_d[k] = sr_q[k-1];
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr_q <= '{default: '0};
        else sr_q <= sr_d;
      assign out_vec[i*BIT_WIDTH +: BIT_WIDTH] = sr_q[i-1];
    end
  end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: weight/data sequencer for a DEPTH x DEPTH systolic array; SYSTOLIC_SEQ_PERF_EN adds perf_cycles
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 32,
  parameter int DRAIN_CYC = DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  systolic_seq_ctrl_if.slave         bus,
  output logic                       control,
  output logic [BIT_WIDTH*DEPTH-1:0] wt_arr,
  output logic [BIT_WIDTH*DEPTH-1:0] data_arr,
  input  logic [ACC_WIDTH*DEPTH-1:0] acc_in,
  output logic [ACC_WIDTH*DEPTH-1:0] result,
  output logic                       result_valid,
  output logic                       busy
`ifdef SYSTOLIC_SEQ_PERF_EN
  ,
  output logic [PERF_W-1:0]          perf_cycles
`endif
);
  localparam int FL = feed_len(DEPTH);
  localparam int CW = cnt_w(DEPTH, DRAIN_CYC);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int VW = BIT_WIDTH * DEPTH;
  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [VW-1:0]            wbuf_q [DEPTH];
  logic [VW-1:0]            wbuf_d [DEPTH];
  logic [VW-1:0]            dbuf_q [DEPTH];
  logic [VW-1:0]            dbuf_d [DEPTH];
  logic [ACC_WIDTH*DEPTH-1:0] result_q, result_d;
  logic control_q, control_d, w_ready_q, w_ready_d, d_ready_q, d_ready_d;
  logic busy_q, busy_d, rv_q, rv_d;
  logic [IW-1:0] idx;
  logic last_d, last_f, last_r;
  logic [VW-1:0] skew_in, skew_out;
  assign idx    = cnt_q[IW-1:0];
  assign last_d = cnt_q == CW'(DEPTH - 1);
  assign last_f = cnt_q == CW'(FL - 1);
  assign last_r = cnt_q == CW'(DRAIN_CYC - 1);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wbuf_d   = wbuf_q;
    dbuf_d   = dbuf_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = W_COLLECT;
        cnt_d   = '0;
      end
      W_COLLECT: if (bus.w_valid) begin
        wbuf_d[idx] = bus.w_data;
        cnt_d       = last_d ? '0 : cnt_q + 1'b1;
        state_d     = last_d ? W_SHIFT : state_q;
      end
      W_SHIFT: begin
        cnt_d   = last_d ? '0 : cnt_q + 1'b1;
        state_d = last_d ? D_COLLECT : state_q;
      end
      D_COLLECT: if (bus.d_valid) begin
        dbuf_d[idx] = bus.d_data;
        cnt_d       = last_d ? '0 : cnt_q + 1'b1;
        state_d     = last_d ? FEED : state_q;
      end
      FEED: begin
        cnt_d   = last_f ? '0 : cnt_q + 1'b1;
        state_d = !last_f ? state_q : (DRAIN_CYC == 0 ? DONE : DRAIN);
      end
      DRAIN: begin
        cnt_d   = last_r ? '0 : cnt_q + 1'b1;
        state_d = last_r ? DONE : state_q;
      end
      DONE: begin
        result_d = acc_in;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    control_d = state_d == W_SHIFT;
    w_ready_d = state_d == W_COLLECT;
    d_ready_d = state_d == D_COLLECT;
    busy_d    = state_d != IDLE;
    rv_d      = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wbuf_q    <= '{default: '0};
      dbuf_q    <= '{default: '0};
      result_q  <= '0;
      control_q <= 1'b0;
      w_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wbuf_q    <= wbuf_d;
      dbuf_q    <= dbuf_d;
      result_q  <= result_d;
      control_q <= control_d;
      w_ready_q <= w_ready_d;
      d_ready_q <= d_ready_d;
      busy_q    <= busy_d;
      rv_q      <= rv_d;
    end
  // vectors enter unskewed; zeros fed outside FEED keep the skew registers flushed
  assign skew_in = (state_q == FEED && cnt_q < CW'(DEPTH)) ? dbuf_q[idx] : '0;
  systolic_skew_buf #(.DEPTH(DEPTH), .BIT_WIDTH(BIT_WIDTH)) u_skew (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_vec (skew_in),
    .out_vec(skew_out)
  );
  assign data_arr     = state_q == FEED ? skew_out : '0;
  assign wt_arr       = control_q ? wbuf_q[idx] : '0;
  assign control      = control_q;
  assign bus.w_ready  = w_ready_q;
  assign bus.d_ready  = d_ready_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result       = rv_q ? acc_in : result_q;
`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [PERF_W-1:0] pcnt_q, pcnt_d, perf_q, perf_d, pcnt_inc;
  always_comb begin
    pcnt_inc = &pcnt_q ? pcnt_q : pcnt_q + 1'b1;
    pcnt_d   = state_q == IDLE ? '0 : pcnt_inc;
    perf_d   = state_q == DONE ? pcnt_inc : perf_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pcnt_q <= '0;
      perf_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      perf_q <= perf_d;
    end
  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: table-driven job check plus stall and mid-FEED reset sequences
module tb_systolic_seq_ctrl;
  localparam int D = 4, BW = 8, AW = 32;
  logic clk = 0, rst_n = 0, start = 0;
  logic control, result_valid, busy;
  logic [BW*D-1:0] wt_arr, data_arr;
  logic [AW*D-1:0] acc_in, result;
`ifdef SYSTOLIC_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif
  systolic_seq_ctrl_if #(.DEPTH(D), .BIT_WIDTH(BW)) bus ();
  systolic_seq_ctrl #(.DEPTH(D), .BIT_WIDTH(BW), .ACC_WIDTH(AW), .DRAIN_CYC(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .control(control),
    .wt_arr(wt_arr), .data_arr(data_arr), .acc_in(acc_in), .result(result),
    .result_valid(result_valid), .busy(busy)
`ifdef SYSTOLIC_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic st, wv, dv;
    logic [31:0] wd, dd;
    logic ctl, bsy, wr, dr, rv;
    logic [31:0] wt, da;
    logic [127:0] res;
  } vec_t;
  vec_t tv[$];
  int errs = 0, checks = 0;
  logic [31:0] W [4];
  logic [31:0] F [7];
  logic [127:0] ACC, ACC2;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic void add(input logic st, wv, dv, input logic [31:0] wd, dd,
                              input logic ctl, bsy, wr, dr, rv,
                              input logic [31:0] wt, da, input logic [127:0] res);
    vec_t v;
    v = '{st, wv, dv, wd, dd, ctl, bsy, wr, dr, rv, wt, da, res};
    tv.push_back(v);
  endfunction
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n, k, m;
    W = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000};
    F = '{32'h00000001, 32'h00000201, 32'h00030201, 32'h04030201,
          32'h04030200, 32'h04030000, 32'h04000000};
    ACC  = {32'h44, 32'h33, 32'h22, 32'h11};
    ACC2 = {32'h8, 32'h7, 32'h6, 32'h5};
    acc_in = ACC;
    bus.w_valid = 0; bus.d_valid = 0; bus.w_data = 0; bus.d_data = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, W[i], 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, W[i], 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 32'h04030201, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(i == 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, F[i], 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, ACC);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ACC);
    @(negedge clk);
    chk("reset_state", {control, wt_arr, data_arr, busy, bus.w_ready, bus.d_ready, result_valid, result}, '0);
    rst_n = 1;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      chk($sformatf("row%0d", i),
          {control, wt_arr, data_arr, busy, bus.w_ready, bus.d_ready, result_valid, result},
          {tv[i].ctl, tv[i].wt, tv[i].da, tv[i].bsy, tv[i].wr, tv[i].dr, tv[i].rv, tv[i].res});
      start = tv[i].st; bus.w_valid = tv[i].wv; bus.w_data = tv[i].wd;
      bus.d_valid = tv[i].dv; bus.d_data = tv[i].dd;
    end
    acc_in = ACC2;
    @(negedge clk);
    chk("result_hold", {result_valid, busy, result}, {2'b00, ACC});
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0; k = 0;
    while (bus.w_ready && n < 40) begin
      bus.w_valid = n[0]; bus.w_data = W[k < 4 ? k : 0];
      if (n[0]) k++;
      n++;
      @(negedge clk);
    end
    bus.w_valid = 0;
    chk("stall_wcollect_cycles", n, 8);
    m = 0;
    while (control && m < 10) begin
      chk($sformatf("stall_wt%0d", m), wt_arr, W[m < 4 ? m : 0]);
      m++;
      @(negedge clk);
    end
    chk("stall_shift_len", m, 4);
    n = 0;
    while (bus.d_ready && n < 40) begin
      bus.d_valid = n[0]; bus.d_data = 32'h08070605;
      n++;
      @(negedge clk);
    end
    bus.d_valid = 0;
    chk("stall_dcollect_cycles", n, 8);
    n = 0;
    while (!result_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("stall_done", {result_valid, busy, result}, {2'b11, ACC2});
    @(negedge clk);
    chk("stall_after_done", {result_valid, busy, result}, {2'b00, ACC2});
    start = 1;
    @(negedge clk);
    start = 0;
    bus.w_valid = 1; bus.d_valid = 1; bus.w_data = 32'h01010101; bus.d_data = 32'h04030201;
    n = 0;
    while (data_arr === '0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    bus.w_valid = 0; bus.d_valid = 0;
    chk("rst_feed_first", {busy, control, data_arr}, {2'b10, 32'h00000001});
    start = 1;
    @(negedge clk);
    start = 0;
    chk("rst_start_ignored", {busy, control, bus.w_ready, data_arr}, {3'b100, 32'h00000201});
    #2 rst_n = 0;
    #1 chk("rst_outputs", {control, wt_arr, data_arr, busy, bus.w_ready, bus.d_ready, result_valid, result}, '0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_idle", {busy, bus.w_ready, control}, 3'b000);
    start = 1;
    @(negedge clk);
    start = 0;
    chk("rst_fresh_collect", {busy, bus.w_ready, bus.d_ready, control}, 4'b1100);
    bus.w_valid = 1;
    n = 0;
    while (bus.w_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    bus.w_valid = 0;
    chk("rst_fresh_beats", {n, control, wt_arr}, {32'd4, 1'b1, 32'h01010101});
    bus.d_valid = 1;
    n = 0;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    bus.d_valid = 0;
    chk("rst_fresh_completes", {busy, result}, {1'b0, ACC2});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
